// File: rtl/top.sv
// Ternary serial master: shifts a balanced-ternary frame counter plus a status trit out
// on O_mosi while sampling I_miso, then reports cmp(rx, tx) as the next frame's status.
module top #(
  parameter int CLK_DIV = 2,
  parameter int TRITS   = 3
) (
  input  logic       I_clk,
  input  logic       I_rst,
  output logic [1:0] O_mosi,
  input  logic [1:0] I_miso,
  output logic [1:0] O_sck
);

  localparam int PW = $clog2(2*CLK_DIV + 1);
  localparam int IW = $clog2(TRITS + 2);
  localparam int DW = 2*TRITS;
  localparam int SW = 2*(TRITS + 1);

  localparam logic [PW-1:0] IDLE_LAST  = PW'(2*CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] STATUS_IDX = IW'(TRITS);

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_INV  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SAMPLE, S_END} state_e;

  function automatic logic trit_valid(input logic [1:0] t);
    case (t)
      T_ZERO, T_POS, T_NEG: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic all_valid(input logic [DW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < TRITS; i++) ok = ok & trit_valid(v[2*i +: 2]);
    return ok;
  endfunction

  // Order -1 < 0 < +1 mapped onto unsigned ranks 0 < 1 < 2.
  function automatic logic [1:0] trit_rank(input logic [1:0] t);
    case (t)
      T_NEG:   return 2'd0;
      T_ZERO:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tern_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [1:0] res;
    logic       decided;
    res     = T_ZERO;
    decided = 1'b0;
    for (int i = TRITS - 1; i >= 0; i--) begin
      if (!decided && (a[2*i +: 2] != b[2*i +: 2])) begin
        decided = 1'b1;
        res     = (trit_rank(a[2*i +: 2]) > trit_rank(b[2*i +: 2])) ? T_POS : T_NEG;
      end
    end
    return res;
  endfunction

  // +1 rolls over to -1 with a carry, so the all-(+1) word wraps to all-(-1).
  function automatic logic [DW-1:0] tern_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < TRITS; i++) begin
      if (carry) begin
        case (v[2*i +: 2])
          T_NEG:   begin r[2*i +: 2] = T_ZERO; carry = 1'b0; end
          T_ZERO:  begin r[2*i +: 2] = T_POS;  carry = 1'b0; end
          default: begin r[2*i +: 2] = T_NEG;  carry = 1'b1; end
        endcase
      end
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   count_q, count_d;
  logic [1:0]      status_q, status_d;
  logic [1:0]      mosi_q, mosi_d;
  logic [1:0]      sck_q, sck_d;
  logic            phase_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rx_q     <= '0;
      count_q  <= '0;
      status_q <= T_INV;
      mosi_q   <= T_ZERO;
      sck_q    <= T_ZERO;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      count_q  <= count_d;
      status_q <= status_d;
      mosi_q   <= mosi_d;
      sck_q    <= sck_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    phase_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_done = (phase_q == IDLE_LAST);
        if (phase_done) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        phase_done = (phase_q == HALF_LAST);
        if (phase_done) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        phase_done = (phase_q == HALF_LAST);
        if (phase_done) state_d = (idx_q == STATUS_IDX) ? S_END : S_LAUNCH;
      end
      default: begin
        phase_done = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    phase_d  = (state_d != state_q) ? '0 : phase_q + PW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    count_d  = count_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (phase_done) begin
          shift_d = {count_q, status_q};
          idx_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (phase_done) begin
          if (idx_q < STATUS_IDX) rx_d = {rx_q[DW-3:0], I_miso};
          shift_d = {shift_q[SW-3:0], T_ZERO};
          idx_d   = idx_q + IW'(1);
        end
      end
      S_END: begin
        status_d = all_valid(rx_q) ? tern_cmp(rx_q, count_q) : T_INV;
        count_d  = tern_inc(count_q);
      end
      default: ;
    endcase

    sck_d  = T_ZERO;
    mosi_d = T_ZERO;
    case (state_d)
      S_LAUNCH: begin sck_d = T_POS; mosi_d = shift_d[SW-1 -: 2]; end
      S_SAMPLE: begin sck_d = T_NEG; mosi_d = shift_d[SW-1 -: 2]; end
      default: ;
    endcase
  end

  assign O_mosi = mosi_q;
  assign O_sck  = sck_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for the ternary serial master: captures whole 21-cycle frames of
// O_sck/O_mosi and compares them with hand-derived frame contents.
module tb_top;

  localparam int FRAME = 21;
  typedef logic [2*FRAME-1:0] seq_t;

  logic       I_clk  = 1'b0;
  logic       I_rst  = 1'b1;
  logic [1:0] I_miso = 2'b11;
  logic [1:0] O_mosi;
  logic [1:0] O_sck;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 I_clk = ~I_clk;

  top #(.CLK_DIV(2), .TRITS(3)) dut (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .O_mosi(O_mosi),
    .I_miso(I_miso),
    .O_sck (O_sck)
  );

  // Cycle c of a frame: 0-3 idle, then per trit k two launch and two sample cycles, 20 = end.
  function automatic seq_t exp_sck();
    seq_t r;
    for (int c = 0; c < FRAME; c++) begin
      if (c < 4 || c == 20) r[2*c +: 2] = 2'b00;
      else if (((c - 4) % 4) < 2) r[2*c +: 2] = 2'b01;
      else r[2*c +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic seq_t exp_mosi(input logic [5:0] cnt, input logic [1:0] st);
    seq_t       r;
    logic [7:0] w;
    w = {cnt, st};
    for (int c = 0; c < FRAME; c++) begin
      if (c < 4 || c == 20) r[2*c +: 2] = 2'b00;
      else r[2*c +: 2] = w[2*(3 - (c - 4) / 4) +: 2];
    end
    return r;
  endfunction

  // Counter trits as seen on the first launch cycle of each data slot.
  function automatic logic [5:0] obs_cnt(input seq_t m);
    return {m[2*4 +: 2], m[2*8 +: 2], m[2*12 +: 2]};
  endfunction

  // Integer -> 3-trit balanced ternary, MSB first.
  function automatic logic [5:0] enc(input int n);
    logic [5:0] r;
    int         v;
    int         rem;
    v = n;
    for (int i = 0; i < 3; i++) begin
      rem = ((v % 3) + 3) % 3;
      if (rem == 0) begin r[2*i +: 2] = 2'b00; v = v / 3; end
      else if (rem == 1) begin r[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
      else begin r[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
    end
    return r;
  endfunction

  // Starts on the negedge of frame cycle 0 and ends on the negedge of the next frame's cycle 0.
  // Slots outside the three data trits are driven with 11 so a stray sample would poison the status.
  task automatic run_frame(input logic [5:0] miso_word, output seq_t sck_seq, output seq_t mosi_seq);
    for (int c = 0; c < FRAME; c++) begin
      sck_seq[2*c +: 2]  = O_sck;
      mosi_seq[2*c +: 2] = O_mosi;
      if (c >= 4 && c < 16) I_miso = miso_word[2*(2 - (c - 4) / 4) +: 2];
      else I_miso = 2'b11;
      @(negedge I_clk);
    end
  endtask

  task automatic test_reset();
    I_rst = 1'b1;
    repeat (3) @(negedge I_clk);
    tests_run++;
    if (O_mosi !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mosi: got %b expected 00", O_mosi);
    end
    tests_run++;
    if (O_sck !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_sck: got %b expected 00", O_sck);
    end
    I_rst = 1'b0;
  endtask

  // Frame 0 with an undriven-looking (invalid 11) receive line.
  task automatic test_first_frame();
    seq_t s, m;
    run_frame(6'b111111, s, m);
    tests_run++;
    if (s !== exp_sck()) begin
      tests_failed++;
      $display("FAIL frame0_sck: got %h expected %h", s, exp_sck());
    end
    tests_run++;
    if (m !== exp_mosi(6'b000000, 2'b11)) begin
      tests_failed++;
      $display("FAIL frame0_mosi: got %h expected %h", m, exp_mosi(6'b000000, 2'b11));
    end
  endtask

  // Frames 1..6: tx counter, expected status (from the previous frame) and the miso word driven.
  logic [5:0] cmp_cnt  [6] = '{6'b000001, 6'b000110, 6'b000100, 6'b000101, 6'b011010, 6'b011000};
  logic [1:0] cmp_st   [6] = '{2'b11,     2'b10,     2'b00,     2'b01,     2'b11,     2'b10};
  logic [5:0] cmp_miso [6] = '{6'b000010, 6'b000110, 6'b010000, 6'b001101, 6'b101010, 6'b000000};

  task automatic test_compare();
    seq_t s, m;
    for (int i = 0; i < 6; i++) begin
      run_frame(cmp_miso[i], s, m);
      tests_run++;
      if (m !== exp_mosi(cmp_cnt[i], cmp_st[i])) begin
        tests_failed++;
        $display("FAIL compare_frame%0d_mosi: got %h expected %h", i + 1, m,
                 exp_mosi(cmp_cnt[i], cmp_st[i]));
      end
      if (i == 0) begin
        tests_run++;
        if (s !== exp_sck()) begin
          tests_failed++;
          $display("FAIL frame1_sck: got %h expected %h", s, exp_sck());
        end
      end
    end
  endtask

  // Frames 7..27 with miso = 0; counter runs +7..+13, wraps to -13, and returns to 0.
  task automatic test_wrap();
    seq_t       s, m;
    logic [1:0] st_exp;
    int         n;
    st_exp = 2'b10;  // frame 6 received 0 against tx +6
    for (int f = 7; f <= 27; f++) begin
      n = (f <= 13) ? f : f - 27;
      run_frame(6'b000000, s, m);
      tests_run++;
      if (m !== exp_mosi(enc(n), st_exp)) begin
        tests_failed++;
        $display("FAIL wrap_frame%0d_mosi: got %h expected %h", f, m, exp_mosi(enc(n), st_exp));
      end
      if (f == 13 || f == 14 || f == 27) begin
        tests_run++;
        if (obs_cnt(m) !== ((f == 13) ? 6'b010101 : (f == 14) ? 6'b101010 : 6'b000000)) begin
          tests_failed++;
          $display("FAIL wrap_counter_f%0d: got %b", f, obs_cnt(m));
        end
      end
      st_exp = (0 > n) ? 2'b01 : (0 < n) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_mid_reset();
    seq_t s, m;
    repeat (8) @(negedge I_clk);
    tests_run++;
    if (O_sck !== 2'b01) begin
      tests_failed++;
      $display("FAIL midrst_launch_sck: got %b expected 01", O_sck);
    end
    I_rst = 1'b1;
    @(negedge I_clk);
    tests_run++;
    if (O_sck !== 2'b00 || O_mosi !== 2'b00) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got sck %b mosi %b expected 00 00", O_sck, O_mosi);
    end
    repeat (2) @(negedge I_clk);
    I_rst = 1'b0;
    run_frame(6'b000000, s, m);
    tests_run++;
    if (m !== exp_mosi(6'b000000, 2'b11)) begin
      tests_failed++;
      $display("FAIL midrst_restart_mosi: got %h expected %h", m, exp_mosi(6'b000000, 2'b11));
    end
    run_frame(6'b111111, s, m);
    tests_run++;
    if (m !== exp_mosi(6'b000001, 2'b00)) begin
      tests_failed++;
      $display("FAIL midrst_back_to_back_mosi: got %h expected %h", m, exp_mosi(6'b000001, 2'b00));
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_compare();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
